// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the ALU/UART sequencer: FSM states,
// frame layout and the nibble-to-ASCII hex encoder.
package alu_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      CAPTURE,
      LOAD,
      WAIT_ACK,
      WAIT_DONE
   } state_e;

   localparam int         FRAME_LEN = 4;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;

   // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/alu_uart_sequencer.sv
// Control FSM: latches operands, runs the ALU for a fixed latency, then sends
// the 8-bit result as a 4-byte ASCII frame (hex-hi, hex-lo, CR, LF) to the UART TX.
module alu_uart_sequencer
   import alu_uart_pkg::*;
#(
   parameter int ALU_LATENCY = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       save_a,
   input  logic       save_b,
   input  logic [3:0] data_in,
   input  logic [3:0] op_in,
   input  logic       go,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_result,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       seq_busy,
   output logic [7:0] result_q,
   output logic       ack_err
);

   localparam int CNT_MAX = (ALU_LATENCY > ACK_TIMEOUT) ? ALU_LATENCY : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LATENCY - 1);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [1:0]       IDX_LAST = 2'(FRAME_LEN - 1);

   state_e           state_q,    state_d;
   logic [3:0]       alu_a_q,    alu_a_d;
   logic [3:0]       alu_b_q,    alu_b_d;
   logic [3:0]       alu_op_q,   alu_op_d;
   logic [7:0]       tx_data_q,  tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             seq_busy_q, seq_busy_d;
   logic [7:0]       res_q,      res_d;
   logic             ack_err_q,  ack_err_d;
   logic [1:0]       idx_q,      idx_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic [7:0] frame_byte;
   logic       byte_done;

   always_comb begin
      case (idx_q)
         2'd0:    frame_byte = nibble_to_ascii(res_q[7:4]);
         2'd1:    frame_byte = nibble_to_ascii(res_q[3:0]);
         2'd2:    frame_byte = ASCII_CR;
         default: frame_byte = ASCII_LF;
      endcase
   end

   always_comb begin
      // NOTE: every _d starts from its held value so no branch can leave it unassigned and infer a latch.
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      res_d      = res_q;
      ack_err_d  = ack_err_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      byte_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (save_a) alu_a_d = data_in;
            if (save_b) alu_b_d = data_in;
            if (go) begin
               alu_op_d  = op_in;
               ack_err_d = 1'b0;
               cnt_d     = '0;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == LAT_LAST) state_d = CAPTURE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         CAPTURE: begin
            res_d   = alu_result;
            idx_d   = '0;
            state_d = LOAD;
         end
         LOAD: begin
            if (!tx_busy) begin
               tx_data_d  = frame_byte;
               tx_start_d = 1'b1;
               cnt_d      = '0;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == ACK_LAST) begin
               // UART never acknowledged: flag it and move on as if the byte went out.
               ack_err_d = 1'b1;
               byte_done = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) byte_done = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (byte_done) begin
         if (idx_q == IDX_LAST) begin
            state_d = IDLE;
         end else begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
         end
      end

      seq_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values, independent of statement order.
      if (reset) begin
         state_q    <= IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         seq_busy_q <= 1'b0;
         res_q      <= '0;
         ack_err_q  <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         seq_busy_q <= seq_busy_d;
         res_q      <= res_d;
         ack_err_q  <= ack_err_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign seq_busy = seq_busy_q;
   assign result_q = res_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench: each frame pushes its hand-computed bytes; a negedge
// monitor pops and compares on every tx_start pulse.
module tb_alu_uart_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       save_a = 1'b0;
   logic       save_b = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic [3:0] op_in = 4'h0;
   logic       go = 1'b0;
   logic [3:0] alu_a, alu_b, alu_op;
   logic [7:0] alu_result;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       seq_busy;
   logic [7:0] result_q;
   logic       ack_err;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt = 0;
   logic [7:0] exp_q[$];

   alu_uart_sequencer #(.ALU_LATENCY(2), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .save_a(save_a), .save_b(save_b),
      .data_in(data_in), .op_in(op_in), .go(go),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .seq_busy(seq_busy), .result_q(result_q), .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   // ALU model, 2-cycle latency: op 0 add, op 1 multiply, op 2 concatenate {a,b}.
   logic [7:0] alu_s1 = 8'h00, alu_s2 = 8'h00;
   always @(posedge clk) begin
      case (alu_op)
         4'd0:    alu_s1 <= {4'h0, alu_a} + {4'h0, alu_b};
         4'd1:    alu_s1 <= alu_a * alu_b;
         4'd2:    alu_s1 <= {alu_a, alu_b};
         default: alu_s1 <= 8'h00;
      endcase
      alu_s2 <= alu_s1;
   end
   assign alu_result = alu_s2;

   // UART model: busy for 10 cycles starting the cycle after tx_start, unless acks are disabled.
   logic uart_ack = 1'b1;
   logic force_busy = 1'b0;
   logic busy_m = 1'b0;
   int   bcnt = 0;
   always @(posedge clk) begin
      if (tx_start && uart_ack && !busy_m) begin
         busy_m <= 1'b1;
         bcnt   <= 9;
      end else if (busy_m) begin
         if (bcnt == 0) busy_m <= 1'b0;
         else           bcnt   <= bcnt - 1;
      end
   end
   assign tx_busy = busy_m | force_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_start_unexpected: got byte 0x%0h, expected no pulse", tx_data);
         end else begin
            check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
      data_in = a; save_a = 1'b1;
      step();
      save_a = 1'b0; data_in = b; save_b = 1'b1;
      step();
      save_b = 1'b0;
   endtask

   task automatic pulse_go(input logic [3:0] op);
      op_in = op; go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] hi, input logic [7:0] lo);
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!seq_busy) break;
      end
      check("seq_busy_idle", {31'h0, seq_busy}, 32'h0);
   endtask

   task automatic finish_frame(input int base, input logic [7:0] exp_res, input logic exp_ae,
                               input int budget);
      wait_idle(budget);
      check("result_q", {24'h0, result_q}, {24'h0, exp_res});
      check("ack_err", {31'h0, ack_err}, {31'h0, exp_ae});
      check("tx_start_pulses", pulse_cnt - base, 4);
      check("exp_queue_empty", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_alu_a", {28'h0, alu_a}, 32'h0);
      check("rst_alu_b", {28'h0, alu_b}, 32'h0);
      check("rst_alu_op", {28'h0, alu_op}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_tx_start", {31'h0, tx_start}, 32'h0);
      check("rst_seq_busy", {31'h0, seq_busy}, 32'h0);
      check("rst_result_q", {24'h0, result_q}, 32'h0);
      check("rst_ack_err", {31'h0, ack_err}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();

      // 3 + 5 = 0x08 -> "08\r\n"
      base = pulse_cnt;
      push_frame(8'h30, 8'h38);
      load_ops(4'h3, 4'h5);
      pulse_go(4'd0);
      finish_frame(base, 8'h08, 1'b0, 200);

      // {A,F} = 0xAF -> "AF\r\n"
      step();
      base = pulse_cnt;
      push_frame(8'h41, 8'h46);
      load_ops(4'hA, 4'hF);
      pulse_go(4'd2);
      finish_frame(base, 8'hAF, 1'b0, 200);

      // {0,9} = 0x09 -> "09\r\n"
      step();
      base = pulse_cnt;
      push_frame(8'h30, 8'h39);
      load_ops(4'h0, 4'h9);
      pulse_go(4'd2);
      finish_frame(base, 8'h09, 1'b0, 200);

      // go and save_a mid-frame are ignored
      step();
      base = pulse_cnt;
      push_frame(8'h30, 8'h38);
      load_ops(4'h3, 4'h5);
      pulse_go(4'd0);
      repeat (8) step();
      data_in = 4'h7; save_a = 1'b1; op_in = 4'd1; go = 1'b1;
      step();
      save_a = 1'b0; go = 1'b0;
      @(negedge clk);
      check("mid_alu_a", {28'h0, alu_a}, 32'h3);
      check("mid_alu_b", {28'h0, alu_b}, 32'h5);
      check("mid_alu_op", {28'h0, alu_op}, 32'h0);
      finish_frame(base, 8'h08, 1'b0, 200);

      // UART never acknowledges: every byte times out, ack_err set
      step();
      uart_ack = 1'b0;
      base = pulse_cnt;
      push_frame(8'h30, 8'h33);
      load_ops(4'h1, 4'h2);
      pulse_go(4'd0);
      finish_frame(base, 8'h03, 1'b1, 300);

      // next go clears ack_err
      uart_ack = 1'b1;
      step();
      base = pulse_cnt;
      push_frame(8'h30, 8'h33);
      pulse_go(4'd0);
      @(negedge clk);
      check("go_clears_ack_err", {31'h0, ack_err}, 32'h0);
      finish_frame(base, 8'h03, 1'b0, 200);

      // tx_busy held high on entry to LOAD: no start until it drops
      step();
      force_busy = 1'b1;
      base = pulse_cnt;
      push_frame(8'h30, 8'h38);
      load_ops(4'h3, 4'h5);
      pulse_go(4'd0);
      repeat (12) step();
      @(negedge clk);
      check("held_busy_no_start", pulse_cnt - base, 0);
      force_busy = 1'b0;
      finish_frame(base, 8'h08, 1'b0, 200);

      // reset during WAIT_DONE of byte 1 aborts the frame
      step();
      base = pulse_cnt;
      push_frame(8'h41, 8'h46);
      load_ops(4'hA, 4'hF);
      pulse_go(4'd2);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((pulse_cnt - base) == 2 && tx_busy) break;
      end
      check("reached_byte1_busy", pulse_cnt - base, 2);
      step();
      step();
      reset = 1'b1;
      exp_q.delete();
      step();
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      repeat (20) step();
      check("no_start_after_reset", pulse_cnt - base, 2);

      // full frame after the abort
      step();
      base = pulse_cnt;
      push_frame(8'h30, 8'h38);
      load_ops(4'h3, 4'h5);
      pulse_go(4'd0);
      finish_frame(base, 8'h08, 1'b0, 200);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
